// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared rounding enum and width/range helpers for the fixed-point resize pipe
package fp_pkg;

  typedef enum logic {
    TRUNC   = 1'b0,
    HALF_UP = 1'b1
  } fp_round_e;

  localparam int FP_MAXW = 128;

  // One extra bit so a rounding carry out of the top never wraps.
  function automatic int fp_s1_width(input int in_iw, input int out_qw);
    return in_iw + out_qw + 1;
  endfunction

  function automatic logic signed [FP_MAXW-1:0] fp_max(input int w);
    logic signed [FP_MAXW-1:0] one;
    one = {{(FP_MAXW-1){1'b0}}, 1'b1};
    return (one <<< (w - 1)) - one;
  endfunction

  function automatic logic signed [FP_MAXW-1:0] fp_min(input int w);
    logic signed [FP_MAXW-1:0] one;
    one = {{(FP_MAXW-1){1'b0}}, 1'b1};
    return -(one <<< (w - 1));
  endfunction

endpackage

// File: rtl/fp_sat.sv
// rtl/fp_sat.sv - combinational range check and saturate/wrap of an aligned value
module fp_sat
  import fp_pkg::*;
#(
  parameter int S1W   = 25,
  parameter int OUT_W = 16
) (
  input  logic signed [S1W-1:0]   s1_val,
  input  logic                    should_clip,
  output logic        [OUT_W-1:0] out_val,
  output logic                    clipping
);

  localparam logic signed [FP_MAXW-1:0] MAX_V = fp_max(OUT_W);
  localparam logic signed [FP_MAXW-1:0] MIN_V = fp_min(OUT_W);
  localparam logic [OUT_W-1:0] MAX_O = MAX_V[OUT_W-1:0];
  localparam logic [OUT_W-1:0] MIN_O = MIN_V[OUT_W-1:0];

  logic signed [FP_MAXW-1:0] wide;

  always_comb begin
    wide     = FP_MAXW'(s1_val);
    clipping = (wide > MAX_V) || (wide < MIN_V);
    out_val  = wide[OUT_W-1:0];
    if (clipping && should_clip) begin
      out_val = wide[FP_MAXW-1] ? MIN_O : MAX_O;
    end
  end

endmodule

// File: rtl/fp_resize_pipe.sv
// rtl/fp_resize_pipe.sv - two-stage fixed-point resize: S1 align/round, S2 saturate/wrap
// Optional clipped-beat counter built when FP_RESIZE_CLIP_CNT_EN is defined.
module fp_resize_pipe
  import fp_pkg::*;
#(
  parameter int IN_IW  = 16,
  parameter int IN_QW  = 16,
  parameter int OUT_IW = 8,
  parameter int OUT_QW = 8,
  parameter int ROUND  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_IW+IN_QW-1:0]   in_data,
  input  logic                     should_clip,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_IW+OUT_QW-1:0] out_data,
  output logic                     clipping
`ifdef FP_RESIZE_CLIP_CNT_EN
  ,
  input  logic                     clip_cnt_clr,
  output logic [15:0]              clip_cnt
`endif
);

  localparam int IN_W  = IN_IW + IN_QW;
  localparam int OUT_W = OUT_IW + OUT_QW;
  localparam int S1W   = fp_s1_width(IN_IW, OUT_QW);
  localparam fp_round_e RMODE = (ROUND != 0) ? HALF_UP : TRUNC;

  logic signed [S1W-1:0] align;

  if (OUT_QW >= IN_QW) begin : g_widen
    localparam int SH = OUT_QW - IN_QW;
    assign align = S1W'($signed(in_data)) <<< SH;
  end else begin : g_narrow
    localparam int D = IN_QW - OUT_QW;
    localparam logic [IN_W:0] ONE  = {{IN_W{1'b0}}, 1'b1};
    localparam logic [IN_W:0] BIAS = (RMODE == HALF_UP) ? (ONE << (D - 1)) : '0;
    logic signed [IN_W:0] ext;
    // Sign-extended by one bit so adding the half-LSB bias cannot overflow.
    assign ext   = {in_data[IN_W-1], in_data} + BIAS;
    assign align = S1W'(ext >>> D);
  end

  logic                  s1_valid_q, s1_valid_d;
  logic signed [S1W-1:0] s1_val_q, s1_val_d;
  logic                  s1_clip_q, s1_clip_d;
  logic                  out_valid_q, out_valid_d;
  logic [OUT_W-1:0]      out_data_q, out_data_d;
  logic                  clipping_q, clipping_d;
  logic [OUT_W-1:0]      sat_val;
  logic                  sat_clip;
  logic                  s1_adv, s2_adv;

  fp_sat #(
    .S1W   (S1W),
    .OUT_W (OUT_W)
  ) u_sat (
    .s1_val      (s1_val_q),
    .should_clip (s1_clip_q),
    .out_val     (sat_val),
    .clipping    (sat_clip)
  );

  always_comb begin
    s2_adv      = !out_valid_q || out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    s1_valid_d  = s1_valid_q;
    s1_val_d    = s1_val_q;
    s1_clip_d   = s1_clip_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    clipping_d  = clipping_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_val_d  = align;
        s1_clip_d = should_clip;
      end
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = sat_val;
        clipping_d = sat_clip;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_val_q    <= '0;
      s1_clip_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      clipping_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_val_q    <= s1_val_d;
      s1_clip_q   <= s1_clip_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      clipping_q  <= clipping_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign clipping  = clipping_q;

`ifdef FP_RESIZE_CLIP_CNT_EN
  logic [15:0] clip_cnt_q, clip_cnt_d;

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (clip_cnt_clr) begin
      clip_cnt_d = '0;
    end else if (out_valid_q && out_ready && clipping_q && (clip_cnt_q != 16'hFFFF)) begin
      clip_cnt_d = clip_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_cnt_q <= '0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign clip_cnt = clip_cnt_q;
`endif

endmodule

// File: doc/fp_resize_pipe.md
FP_RESIZE_PIPE -- requirements
Module: fp_resize_pipe

Interface
REQ-001 SHALL have parameter IN_IW, default 16, meaning input integer bits, including sign.
REQ-002 SHALL have parameter IN_QW, default 16, meaning input fractional bits.
REQ-003 SHALL have parameter OUT_IW, default 8, meaning output integer bits, including sign.
REQ-004 SHALL have parameter OUT_QW, default 8, meaning output fractional bits.
REQ-005 SHALL have parameter ROUND, default 1, meaning 0 = truncate toward -inf and 1 = round-half-up on dropped fraction.
REQ-006 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n  in  1  meaning asynchronous, active-low reset.
REQ-008 SHALL have port in_valid  in  1  meaning an input beat is offered.
REQ-009 SHALL have port in_ready  out  1  meaning the block accepts the beat this cycle.
REQ-010 SHALL have port in_data  in  IN_IW+IN_QW  meaning the signed two's-complement raw input value.
REQ-011 SHALL have port should_clip  in  1  meaning per-beat mode: 1 = saturate, 0 = wrap.
REQ-012 SHALL have port out_valid  out  1  meaning the result beat is valid.
REQ-013 SHALL have port out_ready  in  1  meaning the downstream stage accepts the beat.
REQ-014 SHALL have port out_data  out  OUT_IW+OUT_QW  meaning the signed resized raw value.
REQ-015 SHALL have port clipping  out  1  meaning the beat's value lay outside the output range.
REQ-016 SHALL, when FP_RESIZE_CLIP_CNT_EN is defined, have port clip_cnt_clr  in  1  meaning synchronous counter clear.
REQ-017 SHALL, when FP_RESIZE_CLIP_CNT_EN is defined, have port clip_cnt  out  16  meaning the count of clipped output beats.

Function
REQ-018 SHALL implement two pipeline stages: S1 = fractional align/round, S2 = range check and saturate/wrap.
REQ-019 SHALL transfer a beat when valid && ready on the same edge; latency is in-accept to out_valid = 2 cycles.
REQ-020 SHALL advance each stage when it is empty or the next stage frees this cycle; in_ready = !S1_valid || S1 advancing.
REQ-021 SHALL sustain throughput of 1 beat/cycle with out_ready held high.
REQ-022 SHALL hold out_data/clipping stable while out_valid && !out_ready, and SHALL neither drop, duplicate nor reorder beats.
REQ-023 SHALL, if OUT_QW >= IN_QW, left-shift by OUT_QW-IN_QW with zero fill.
REQ-024 SHALL, if OUT_QW < IN_QW with ROUND=0, arithmetic-right-shift by d = IN_QW-OUT_QW.
REQ-025 SHALL, if OUT_QW < IN_QW with ROUND=1, add 2^(d-1) then arithmetic-right-shift by d.
REQ-026 SHALL carry S1 results one bit wider than needed so that a rounding carry is never lost.
REQ-027 SHALL set clipping=1 iff the S1 value is outside [-2^(OUT_IW+OUT_QW-1), 2^(OUT_IW+OUT_QW-1)-1], independent of should_clip.
REQ-028 SHALL, on clipping with should_clip=1, output the max or min representable value by sign; with should_clip=0, output the low OUT_IW+OUT_QW bits.
REQ-029 SHALL, when clipping=0, output the aligned value exactly; a pure widening (OUT_IW>=IN_IW, OUT_QW>=IN_QW) never clips.
REQ-030 SHALL register should_clip with its data beat, so that mode changes affect only subsequently accepted beats.

Reset
REQ-031 SHALL, while rst_n=0, clear both stage valids, out_valid=0, out_data=0, clipping=0 and clip_cnt=0; in_ready reads 1.
REQ-032 SHALL discard in-flight beats on reset mid-operation, and SHALL produce the first out_valid no earlier than 2 cycles after the first post-reset accept.

Configuration
REQ-033 SHALL, with FP_RESIZE_CLIP_CNT_EN defined, increment clip_cnt on each out_valid && out_ready && clipping, saturating at 0xFFFF.
REQ-034 SHALL let clip_cnt_clr take priority over a same-cycle increment, yielding 0.
REQ-035 SHALL, with FP_RESIZE_CLIP_CNT_EN undefined, omit the counter, the clip_cnt_clr port and the clip_cnt port, with all other behaviour identical.

Structure
REQ-036 SHALL place the fp_round_e enum (TRUNC, HALF_UP) and the width/min/max helper functions in the shared package fp_pkg.
REQ-037 SHALL isolate the S2 range-check/saturate logic as the sub-module fp_sat, which is combinational.

Verification
REQ-038 SHALL cover widening 16.16 to 32.32 with in=0x0001_8000 -> out=0x00000001_80000000, clipping=0, 2 cycles later.
REQ-039 SHALL cover saturation 16.16 to 8.8 with in=0x7FFF_0000 and should_clip=1 -> 0x7FFF with clipping=1, and should_clip=0 -> 0xFF00 with clipping=1.
REQ-040 SHALL cover rounding 16.16 to 8.8 with in=0x0000_0080 -> 0x0001 for ROUND=1 and 0x0000 for ROUND=0, and in=0xFFFF_FF80 with ROUND=1 -> 0x0000.
REQ-041 SHALL cover backpressure: 4 back-to-back beats with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, then all 4 emerge in order.
REQ-042 SHALL cover reset mid-stream: rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately and no stale beat afterwards.
REQ-043 SHALL cover the counter (macro on): 3 clipped beats accepted, clip_cnt_clr asserted on the same cycle as a 4th -> clip_cnt=3, then 0.
